// File: rtl/corriente_setpoint_ctrl.sv
// Current-setpoint controller: button stepping with hold/auto-repeat, wrap or
// saturate at the limits, direct load, and a registered current-limit table.
module corriente_setpoint_ctrl #(
    parameter int WIDTH         = 10,
    parameter int MIN           = 0,
    parameter int MAX           = 1000,
    parameter int STEP          = 20,
    parameter int INIT          = 500,
    parameter int WRAP          = 1,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic [2:0]       sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] setpoint,
    output logic [WIDTH-1:0] limit,
    output logic             at_min,
    output logic             at_max,
    output logic             changed
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             dir_up;
    logic             prev_up;
    logic             prev_dn;

    logic             act_up;
    logic             act_dn;
    logic             held_ok;
    logic             step_up;
    logic             step_dn;
    logic [WIDTH:0]   sp_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   up_val;
    logic [WIDTH:0]   dn_val;
    logic [WIDTH:0]   step_val;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   load_c;
    logic [WIDTH-1:0] limit_nxt;

    always_comb begin
        act_up  = up & ~down;
        act_dn  = down & ~up;
        held_ok = dir_up ? act_up : act_dn;

        step_up = 1'b0;
        step_dn = 1'b0;
        case (state)
            ST_IDLE: begin
                step_up = act_up & ~prev_up;
                step_dn = act_dn & ~prev_dn;
            end
            ST_HOLD: begin
                step_up = held_ok & dir_up & (counter == HOLD_TC);
                step_dn = held_ok & ~dir_up & (counter == HOLD_TC);
            end
            ST_RPT: begin
                step_up = held_ok & dir_up & (counter == RPT_TC);
                step_dn = held_ok & ~dir_up & (counter == RPT_TC);
            end
            default: begin
                step_up = 1'b0;
                step_dn = 1'b0;
            end
        endcase

        // One extra bit keeps setpoint+STEP from wrapping before the clamp
        sp_x  = {1'b0, setpoint};
        sum_x = sp_x + STEP_X;
        if (sp_x == MAX_X)
            up_val = (WRAP != 0) ? MIN_X : MAX_X;
        else
            up_val = (sum_x > MAX_X) ? MAX_X : sum_x;

        if (sp_x == MIN_X)
            dn_val = (WRAP != 0) ? MAX_X : MIN_X;
        else if (sp_x < MIN_X + STEP_X)
            dn_val = MIN_X;
        else
            dn_val = sp_x - STEP_X;

        step_val = step_up ? up_val : dn_val;

        load_x = {1'b0, load_val};
        if (load_x < MIN_X)
            load_c = MIN_X;
        else if (load_x > MAX_X)
            load_c = MAX_X;
        else
            load_c = load_x;

        case (sel)
            3'd0:    limit_nxt = WIDTH'(30);
            3'd1:    limit_nxt = WIDTH'(50);
            3'd2:    limit_nxt = WIDTH'(75);
            3'd3:    limit_nxt = WIDTH'(100);
            3'd4:    limit_nxt = WIDTH'(125);
            3'd5:    limit_nxt = WIDTH'(150);
            3'd6:    limit_nxt = WIDTH'(175);
            default: limit_nxt = WIDTH'(200);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            counter  <= '0;
            dir_up   <= 1'b0;
            // Treat buttons as already active so one held through reset must be re-pressed
            prev_up  <= 1'b1;
            prev_dn  <= 1'b1;
            setpoint <= WIDTH'(INIT);
            limit    <= WIDTH'(30);
            changed  <= 1'b0;
        end else begin
            prev_up <= act_up;
            prev_dn <= act_dn;
            limit   <= limit_nxt;

            if (load) begin
                setpoint <= load_c[WIDTH-1:0];
                changed  <= (load_c != sp_x);
            end else if (step_up | step_dn) begin
                setpoint <= step_val[WIDTH-1:0];
                changed  <= (step_val != sp_x);
            end else begin
                changed  <= 1'b0;
            end

            // A load freezes the sequencer for that cycle
            if (!load) begin
                case (state)
                    ST_IDLE: begin
                        if (step_up | step_dn) begin
                            state   <= ST_HOLD;
                            counter <= '0;
                            dir_up  <= step_up;
                        end
                    end
                    ST_HOLD: begin
                        if (!held_ok) begin
                            state   <= ST_IDLE;
                            counter <= '0;
                        end else if (counter == HOLD_TC) begin
                            state   <= ST_RPT;
                            counter <= '0;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    ST_RPT: begin
                        if (!held_ok) begin
                            state   <= ST_IDLE;
                            counter <= '0;
                        end else if (counter == RPT_TC) begin
                            counter <= '0;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end
                endcase
            end
        end
    end

    assign at_min = (setpoint == WIDTH'(MIN));
    assign at_max = (setpoint == WIDTH'(MAX));

endmodule

// File: tb/tb_corriente_setpoint_ctrl.sv
// Directed bench: a wrapping and a saturating instance share the same stimulus.
module tb_corriente_setpoint_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       load = 1'b0;
    logic [9:0] load_val = 10'd0;

    logic [9:0] sp_w, lim_w, sp_s, lim_s;
    logic       amin_w, amax_w, chg_w, amin_s, amax_s, chg_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    corriente_setpoint_ctrl #(.WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .up(up), .down(down), .sel(sel),
        .load(load), .load_val(load_val), .setpoint(sp_w), .limit(lim_w),
        .at_min(amin_w), .at_max(amax_w), .changed(chg_w)
    );

    corriente_setpoint_ctrl #(.WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .up(up), .down(down), .sel(sel),
        .load(load), .load_val(load_val), .setpoint(sp_s), .limit(lim_s),
        .at_min(amin_s), .at_max(amax_s), .changed(chg_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [9:0] v);
        load = 1'b1; load_val = v;
        tick;
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        n_cmp++; if (sp_w !== 10'd500) begin n_bad++; $display("FAIL reset_sp_w: got %0d want 500", sp_w); end
        n_cmp++; if (sp_s !== 10'd500) begin n_bad++; $display("FAIL reset_sp_s: got %0d want 500", sp_s); end
        n_cmp++; if (lim_w !== 10'd30) begin n_bad++; $display("FAIL reset_limit: got %0d want 30", lim_w); end
        n_cmp++; if (chg_w !== 1'b0) begin n_bad++; $display("FAIL reset_changed: got %b want 0", chg_w); end
        n_cmp++; if ({amin_w, amax_w} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {amin_w, amax_w}); end
    endtask

    task automatic test_wrap;
        do_load(10'd1000);
        n_cmp++; if (sp_w !== 10'd1000 || amax_w !== 1'b1) begin n_bad++; $display("FAIL wrap_load: got %0d/%b want 1000/1", sp_w, amax_w); end
        tick;
        up = 1'b1; tick; up = 1'b0;
        n_cmp++; if (sp_w !== 10'd0) begin n_bad++; $display("FAIL wrap_up_sp: got %0d want 0", sp_w); end
        n_cmp++; if (amin_w !== 1'b1 || chg_w !== 1'b1) begin n_bad++; $display("FAIL wrap_up_flags: got at_min=%b changed=%b want 1 1", amin_w, chg_w); end
        n_cmp++; if (sp_s !== 10'd1000 || chg_s !== 1'b0) begin n_bad++; $display("FAIL sat_up_at_max: got %0d/%b want 1000/0", sp_s, chg_s); end
        tick;
        n_cmp++; if (chg_w !== 1'b0) begin n_bad++; $display("FAIL wrap_changed_pulse: got %b want 0", chg_w); end
        down = 1'b1; tick; down = 1'b0;
        n_cmp++; if (sp_w !== 10'd1000) begin n_bad++; $display("FAIL wrap_down_sp: got %0d want 1000", sp_w); end
        n_cmp++; if (sp_s !== 10'd980) begin n_bad++; $display("FAIL sat_down_sp: got %0d want 980", sp_s); end
        tick;
    endtask

    task automatic test_saturate;
        do_load(10'd990);
        tick;
        up = 1'b1; tick; up = 1'b0;
        n_cmp++; if (sp_s !== 10'd1000 || chg_s !== 1'b1) begin n_bad++; $display("FAIL sat_first_up: got %0d/%b want 1000/1", sp_s, chg_s); end
        tick;
        up = 1'b1; tick; up = 1'b0;
        n_cmp++; if (sp_s !== 10'd1000 || chg_s !== 1'b0) begin n_bad++; $display("FAIL sat_second_up: got %0d/%b want 1000/0", sp_s, chg_s); end
        n_cmp++; if (sp_w !== 10'd0) begin n_bad++; $display("FAIL wrap_second_up: got %0d want 0", sp_w); end
        tick;
        do_load(10'd10);
        tick;
        down = 1'b1; tick; down = 1'b0;
        n_cmp++; if (sp_s !== 10'd0 || amin_s !== 1'b1) begin n_bad++; $display("FAIL sat_down_clamp: got %0d/%b want 0/1", sp_s, amin_s); end
        n_cmp++; if (sp_w !== 10'd0) begin n_bad++; $display("FAIL wrap_down_clamp: got %0d want 0", sp_w); end
        tick;
    endtask

    task automatic test_hold;
        int pulses;
        logic [9:0] exp_sp;
        pulses = 0;
        do_load(10'd500);
        tick;
        up = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (chg_w === 1'b1) pulses++;
            exp_sp = 10'd0;
            case (i)
                1:   exp_sp = 10'd520;
                50:  exp_sp = 10'd520;
                51:  exp_sp = 10'd540;
                61:  exp_sp = 10'd560;
                100: exp_sp = 10'd620;
                default: exp_sp = 10'd0;
            endcase
            if (exp_sp != 10'd0) begin
                n_cmp++;
                if (sp_w !== exp_sp) begin n_bad++; $display("FAIL hold_sp_c%0d: got %0d want %0d", i, sp_w, exp_sp); end
            end
        end
        up = 1'b0;
        tick;
        n_cmp++; if (pulses !== 6) begin n_bad++; $display("FAIL hold_pulses: got %0d want 6", pulses); end
        n_cmp++; if (sp_w !== 10'd620 || chg_w !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %0d/%b want 620/0", sp_w, chg_w); end
    endtask

    task automatic test_both_load;
        up = 1'b1; down = 1'b1;
        do_load(10'd1023);
        n_cmp++; if (sp_w !== 10'd1000 || chg_w !== 1'b1 || amax_w !== 1'b1) begin n_bad++; $display("FAIL load_clamp: got %0d/%b/%b want 1000/1/1", sp_w, chg_w, amax_w); end
        tick; tick; tick;
        n_cmp++; if (sp_w !== 10'd1000 || chg_w !== 1'b0) begin n_bad++; $display("FAIL both_no_step: got %0d/%b want 1000/0", sp_w, chg_w); end
        up = 1'b0;
        tick;
        n_cmp++; if (sp_w !== 10'd980) begin n_bad++; $display("FAIL both_then_down: got %0d want 980", sp_w); end
        down = 1'b0;
        tick;
        do_load(10'd980);
        n_cmp++; if (sp_w !== 10'd980 || chg_w !== 1'b0) begin n_bad++; $display("FAIL load_same: got %0d/%b want 980/0", sp_w, chg_w); end
        up = 1'b1;
        do_load(10'd300);
        n_cmp++; if (sp_w !== 10'd300) begin n_bad++; $display("FAIL load_beats_step: got %0d want 300", sp_w); end
        up = 1'b0;
        tick;
    endtask

    task automatic test_limit;
        int lim_tab[8] = '{30, 50, 75, 100, 125, 150, 175, 200};
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick;
            n_cmp++;
            if (lim_w !== 10'(lim_tab[s])) begin n_bad++; $display("FAIL limit_sel%0d: got %0d want %0d", s, lim_w, lim_tab[s]); end
        end
    endtask

    task automatic test_reset_mid_rpt;
        int pulses;
        pulses = 0;
        do_load(10'd500);
        tick;
        up = 1'b1;
        repeat (70) tick;
        n_cmp++; if (sp_w !== 10'd560) begin n_bad++; $display("FAIL rpt_before_reset: got %0d want 560", sp_w); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++; if (sp_w !== 10'd500 || chg_w !== 1'b0) begin n_bad++; $display("FAIL rpt_reset: got %0d/%b want 500/0", sp_w, chg_w); end
        for (int i = 0; i < 60; i++) begin
            tick;
            if (chg_w === 1'b1) pulses++;
        end
        n_cmp++; if (sp_w !== 10'd500 || pulses !== 0) begin n_bad++; $display("FAIL held_after_reset: got %0d/%0d pulses want 500/0", sp_w, pulses); end
        up = 1'b0; tick;
        up = 1'b1; tick;
        up = 1'b0;
        n_cmp++; if (sp_w !== 10'd520) begin n_bad++; $display("FAIL repress_after_reset: got %0d want 520", sp_w); end
        tick;
    endtask

    initial begin
        test_reset;
        test_wrap;
        test_saturate;
        test_hold;
        test_both_load;
        test_limit;
        test_reset_mid_rpt;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
